// File: rtl/sqmux_sel_ctrl.sv
// SELECT controller for the SQMUX clock-select mux: switches QMUXIN/SQHSCK only
// inside a gated drain/settle window, and falls back to QMUXIN on SQHSCK lock loss.
module sqmux_sel_ctrl #(
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
  output logic REQ_READY,
  input  logic LOCK,
  output logic SELECT,
  output logic GATE_EN,
  output logic BUSY,
  output logic DONE,
  output logic ERR,
  output logic FALLBACK
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SETTLE
  } state_e;

  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;
  logic             select_q, select_d;
  logic             gate_en_q, gate_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fallback_q, fallback_d;
  logic             lock_meta_q, lock_s_q;
  logic             req_ready;
  logic             accept;
  logic             lock_lost;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  // SQHSCK route is selected (or targeted) but its source is no longer locked.
  assign lock_lost = !lock_s_q;
  assign req_ready = (state_q == ST_IDLE) && !(select_q && lock_lost);
  assign accept    = REQ_VALID && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    select_d   = select_q;
    gate_en_d  = gate_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fallback_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (select_q && lock_lost) begin
          state_d    = ST_DRAIN;
          gate_en_d  = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = DRAIN_LOAD;
          target_d   = 1'b0;
          fallback_d = 1'b1;
        end else if (accept) begin
          if (REQ_SEL == select_q) begin
            done_d = 1'b1;
          end else if (REQ_SEL && lock_lost) begin
            err_d = 1'b1;
          end else begin
            state_d   = ST_DRAIN;
            gate_en_d = 1'b0;
            busy_d    = 1'b1;
            cnt_d     = DRAIN_LOAD;
            target_d  = REQ_SEL;
          end
        end
      end

      ST_DRAIN: begin
        // Lock loss wins over the switch edge so SQHSCK is never selected unlocked.
        if (target_q && lock_lost) begin
          state_d   = ST_IDLE;
          gate_en_d = 1'b1;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end else if (cnt_q == '0) begin
          select_d = target_q;
          cnt_d    = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SETTLE: begin
        if (target_q && lock_lost) begin
          select_d   = 1'b0;
          cnt_d      = SETTLE_LOAD;
          target_d   = 1'b0;
          fallback_d = 1'b1;
        end else if (cnt_q == '0) begin
          gate_en_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        gate_en_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= 1'b0;
      select_q   <= 1'b0;
      gate_en_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      select_q   <= select_d;
      gate_en_q  <= gate_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fallback_q <= fallback_d;
    end
  end

  assign REQ_READY = req_ready;
  assign SELECT    = select_q;
  assign GATE_EN   = gate_en_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign FALLBACK  = fallback_q;

  // The mux may only see SELECT move while the downstream gate is closed.
  a_select_gated : assert property (@(posedge CLK) disable iff (!RESET_N)
    (select_d != select_q) |-> (!gate_en_q && !gate_en_d));

endmodule

// File: doc/sqmux_sel_ctrl.md
# sqmux_sel_ctrl

Synchronous controller that generates the SELECT input of the SQMUX clock-select mux. It switches between the QMUXIN route (SELECT=0) and the SQHSCK route (SELECT=1) only inside a gated quiet window. It refuses or reverts the SQHSCK route whenever the high-speed source reports loss of lock. It sits directly upstream of SQMUX, driving SELECT and a downstream clock-gate enable, and runs entirely in the always-on reference clock domain.

## Interface

Parameters:
- DRAIN_CYCLES, 4: cycles GATE_EN is held low before SELECT changes; legal range 1..255.
- SETTLE_CYCLES, 8: cycles after the SELECT change before GATE_EN is restored; legal range 1..255.
- CNT_W, 8: width of the shared phase counter; must hold max(DRAIN_CYCLES, SETTLE_CYCLES).

Ports:
- CLK  input  1  always-on reference clock; all state on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- REQ_VALID  input  1  switch request valid.
- REQ_SEL  input  1  requested SELECT level.
- REQ_READY  output  1  request accepted when REQ_VALID && REQ_READY at a rising edge.
- LOCK  input  1  asynchronous lock/valid indication of the SQHSCK source.
- SELECT  output  1  registered; drives SQMUX SELECT.
- GATE_EN  output  1  registered; enable for the downstream clock gate.
- BUSY  output  1  registered; high in DRAIN/SWITCH/SETTLE.
- DONE  output  1  one-cycle pulse; request or fallback completed.
- ERR  output  1  one-cycle pulse; request rejected or aborted.
- FALLBACK  output  1  one-cycle pulse; automatic revert to SELECT=0 started.

## Operation

- LOCK passes through a 2-flop synchronizer (reset 0) to produce lock_s; all decisions use lock_s.
- States: IDLE, DRAIN, SETTLE. SWITCH is the single edge that ends DRAIN.
- REQ_READY = (state==IDLE) && !(SELECT && !lock_s). It is combinational and is the only unregistered output.
- Acceptance in IDLE, decided at the accepting edge:
  - REQ_SEL==SELECT: no-op. Stay in IDLE; DONE pulses the next cycle.
  - REQ_SEL==1 && !lock_s: reject. Stay in IDLE; ERR pulses the next cycle.
  - Otherwise: go to DRAIN, GATE_EN<=0, BUSY<=1, counter<=DRAIN_CYCLES-1, target<=REQ_SEL.
- DRAIN: decrement the counter. When it reaches 0, at that edge set SELECT<=target and counter<=SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE: decrement. When the counter reaches 0, set GATE_EN<=1, BUSY<=0, DONE<=1 for one cycle, and return to IDLE.
- Fallback: in IDLE with SELECT==1 and lock_s==0, start the DRAIN sequence with target 0 and pulse FALLBACK. This takes priority over any REQ_VALID; REQ_READY is already low.
- Lock loss while target==1:
  - In DRAIN: abort to IDLE. GATE_EN<=1, BUSY<=0, ERR pulse; SELECT stays 0.
  - In SETTLE: SELECT<=0, reload counter<=SETTLE_CYCLES-1, stay in SETTLE, target<=0, pulse FALLBACK. Completion then pulses DONE normally.
- SELECT changes only while GATE_EN is low; this invariant holds in all paths.

## Timing

- Reset values: SELECT=0, GATE_EN=1, BUSY=0, DONE=0, ERR=0, FALLBACK=0, lock_s=0, state IDLE, so REQ_READY=1. Asserting reset mid-sequence returns immediately to these values.
- Accept at edge 0:
  - GATE_EN falls after edge 0.
  - SELECT toggles after edge DRAIN_CYCLES.
  - GATE_EN rises and DONE pulses after edge DRAIN_CYCLES+SETTLE_CYCLES.
  - REQ_READY is high again in the DONE cycle.
- No-op and reject responses come 1 cycle after acceptance.
- LOCK-to-action latency: lock_s updates 2 edges after LOCK; the fallback starts at the following edge.
- With the defaults, a switch takes 12 cycles from acceptance to DONE.

## Test plan

- Reset, then LOCK=1. After 2 cycles, request REQ_SEL=1 at edge 0 -> GATE_EN low from edge 0, SELECT=1 after edge 4, GATE_EN=1 and DONE after edge 12, BUSY high for cycles 1..12.
- SELECT=0, LOCK=0, request REQ_SEL=1 -> ERR pulse 1 cycle later; SELECT, GATE_EN and BUSY unchanged.
- SELECT=1, request REQ_SEL=1 -> DONE 1 cycle later, GATE_EN never drops.
- SELECT=1 in IDLE, drop LOCK -> FALLBACK pulse, REQ_READY low, SELECT=0 after DRAIN_CYCLES, DONE after 12 cycles; a concurrent REQ_VALID is not accepted.
- Request to 1, drop LOCK during DRAIN -> ERR, SELECT stays 0, GATE_EN=1. Repeat with the drop during SETTLE -> SELECT=0, FALLBACK, SETTLE restarts, DONE 8 cycles later.
- Assert RESET_N=0 in the middle of SETTLE -> all outputs return to reset values immediately. Check throughout that SELECT never changes while GATE_EN=1.
